// File: rtl/mips16_pkg.sv
// mips16_pkg -- shared definitions for the MIPS16 program loader.
//   state_t       : loader FSM state encoding
//   OPC_HLT       : opcode field value of the HLT instruction
//   INSTR_W       : instruction word width
//   is_load_state : 1 for states that consume stream bytes
package mips16_pkg;

  localparam int         INSTR_W = 16;
  localparam logic [3:0] OPC_HLT = 4'hF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_CS_HI,
    S_CS_LO,
    S_DONE,
    S_ERR
  } state_t;

  function automatic logic is_load_state(input state_t s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DAT_HI) ||
           (s == S_DAT_LO) || (s == S_CS_HI)  || (s == S_CS_LO);
  endfunction

endpackage

// File: rtl/mips16_byte_pack.sv
// mips16_byte_pack -- assembles big-endian 16-bit words from a byte stream.
// Ports:
//   clk1, rst_n  : clock, async active-low reset
//   accept       : loader wants bytes next cycle (registered into in_ready)
//   in_valid     : byte-stream valid
//   in_data[7:0] : byte-stream data
//   in_ready     : byte-stream ready (registered)
//   byte_fire    : a byte transfers this cycle
//   word_valid   : the low byte of a word transfers this cycle
//   word[15:0]   : {held high byte, in_data}, meaningful with word_valid
module mips16_byte_pack
  import mips16_pkg::*;
(
  input  logic               clk1,
  input  logic               rst_n,
  input  logic               accept,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               byte_fire,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word
);

  logic [7:0] hi_q;
  logic       have_hi;

  // Ready is a pure register of the loader's next-state, so no skid buffer is
  // needed: a byte presented while ready is low simply waits upstream.
  assign byte_fire  = in_valid & in_ready;
  assign word_valid = byte_fire & have_hi;
  assign word       = {hi_q, in_data};

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      hi_q     <= 8'h00;
      have_hi  <= 1'b0;
    end else begin
      in_ready <= accept;
      if (byte_fire) begin
        if (!have_hi) begin
          hi_q    <= in_data;
          have_hi <= 1'b1;
        end else begin
          have_hi <= 1'b0;
        end
      end else if (!in_ready) begin
        have_hi <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mips16_prog_loader.sv
// mips16_prog_loader -- boot loader for pipe_MIPS16. Receives
// {len_hi, len_lo, N x {hi, lo}} over a byte stream, writes the N words to
// instruction memory from BASE_ADDR (wrapping), then releases the core.
// Optional macro MIPS16_LOADER_CHECKSUM_EN: a trailing big-endian 16-bit
// checksum (mod-2^16 word sum) must match or the load ends in ERR.
// Ports:
//   clk1, rst_n                : clock, async active-low reset
//   load_start                 : start/restart a load (ignored while busy)
//   in_valid, in_data, in_ready: byte stream
//   mem_we, mem_addr, mem_wdata: instruction memory write port
//   core_hold, core_start      : core halt level and PC-load pulse
//   start_pc                   : constant BASE_ADDR
//   hlt_seen, busy, error      : status
//
// state    | meaning
// S_IDLE   | after reset, core held, waiting for load_start
// S_LEN_HI | expecting length high byte
// S_LEN_LO | expecting length low byte, range-checked on arrival
// S_DAT_HI | expecting data word high byte
// S_DAT_LO | expecting data word low byte, write issued next cycle
// S_CS_HI  | expecting checksum high byte (checksum build only)
// S_CS_LO  | expecting checksum low byte (checksum build only)
// S_DONE   | image loaded, core released
// S_ERR    | load failed, core held
module mips16_prog_loader
  import mips16_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 256
) (
  input  logic               clk1,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               core_hold,
  output logic               core_start,
  output logic [ADDR_W-1:0]  start_pc,
  output logic               hlt_seen,
  output logic               busy,
  output logic               error
);

  localparam logic [ADDR_W-1:0]  BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [INSTR_W-1:0] MAX_LEN = INSTR_W'(MAX_WORDS);

  state_t             state, state_nx;
  logic               byte_fire, word_valid;
  logic [INSTR_W-1:0] word;
  logic [INSTR_W-1:0] len_q, idx_q;
  logic               restart, len_bad, last_word;
`ifdef MIPS16_LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0] sum_q;
`endif

  mips16_byte_pack u_pack (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .accept    (is_load_state(state_nx)),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .byte_fire (byte_fire),
    .word_valid(word_valid),
    .word      (word)
  );

  assign restart   = load_start &&
                     ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign len_bad   = (word == '0) || (word > MAX_LEN);
  assign last_word = ((idx_q + 16'd1) == len_q);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (load_start) state_nx = S_LEN_HI;
      S_LEN_HI: if (byte_fire)  state_nx = S_LEN_LO;
      S_LEN_LO: if (word_valid) state_nx = len_bad ? S_ERR : S_DAT_HI;
      S_DAT_HI: if (byte_fire)  state_nx = S_DAT_LO;
`ifdef MIPS16_LOADER_CHECKSUM_EN
      S_DAT_LO: if (word_valid) state_nx = last_word ? S_CS_HI : S_DAT_HI;
      S_CS_HI:  if (byte_fire)  state_nx = S_CS_LO;
      S_CS_LO:  if (word_valid) state_nx = (word == sum_q) ? S_DONE : S_ERR;
`else
      S_DAT_LO: if (word_valid) state_nx = last_word ? S_DONE : S_DAT_HI;
`endif
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_start <= 1'b0;
      hlt_seen   <= 1'b0;
      len_q      <= '0;
      idx_q      <= '0;
`ifdef MIPS16_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state      <= state_nx;
      mem_we     <= 1'b0;
      core_start <= (state_nx == S_DONE) && (state != S_DONE);
      if (restart) begin
        idx_q    <= '0;
        hlt_seen <= 1'b0;
`ifdef MIPS16_LOADER_CHECKSUM_EN
        sum_q    <= '0;
`endif
      end
      if ((state == S_LEN_LO) && word_valid) len_q <= word;
      if ((state == S_DAT_LO) && word_valid) begin
        mem_we    <= 1'b1;
        mem_addr  <= BASE + idx_q[ADDR_W-1:0];
        mem_wdata <= word;
        idx_q     <= idx_q + 16'd1;
        if (word[15:12] == OPC_HLT) hlt_seen <= 1'b1;
`ifdef MIPS16_LOADER_CHECKSUM_EN
        sum_q     <= sum_q + word;
`endif
      end
    end
  end

  assign start_pc  = BASE;
  assign busy      = is_load_state(state);
  assign core_hold = (state != S_DONE);
  assign error     = (state == S_ERR);

endmodule

// File: tb/tb_mips16_prog_loader.sv
module tb_mips16_prog_loader;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        in_ready, mem_we, core_hold, core_start, hlt_seen, busy, error;
  logic [7:0]  mem_addr, start_pc;
  logic [15:0] mem_wdata;

  logic        w_in_ready, w_mem_we, w_core_hold, w_core_start, w_hlt_seen, w_busy, w_error;
  logic [7:0]  w_mem_addr, w_start_pc;
  logic [15:0] w_mem_wdata;

  mips16_prog_loader u_dut (
    .clk1(clk1), .rst_n(rst_n), .load_start(load_start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .core_start(core_start), .start_pc(start_pc),
    .hlt_seen(hlt_seen), .busy(busy), .error(error)
  );

  mips16_prog_loader #(.ADDR_W(8), .BASE_ADDR(254), .MAX_WORDS(256)) u_wrap (
    .clk1(clk1), .rst_n(rst_n), .load_start(load_start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(w_in_ready),
    .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
    .core_hold(w_core_hold), .core_start(w_core_start), .start_pc(w_start_pc),
    .hlt_seen(w_hlt_seen), .busy(w_busy), .error(w_error)
  );

  always #5 clk1 = ~clk1;

  int checks = 0;
  int failures = 0;

  logic [7:0]  wa [64];
  logic [15:0] wd [64];
  logic [7:0]  xa [64];
  logic [15:0] xd [64];
  int wn = 0, xn = 0, sc = 0, rbad = 0;
  logic [15:0] img [16];
  logic [15:0] img9 [9] = '{16'h004a, 16'h0094, 16'h00d9, 16'h3ff8, 16'h3ff8,
                            16'h12a0, 16'h3ff8, 16'h18e8, 16'hf000};

  always @(negedge clk1) begin
    if (mem_we) begin
      if (wn < 64) begin wa[wn] = mem_addr; wd[wn] = mem_wdata; end
      wn++;
    end
    if (w_mem_we) begin
      if (xn < 64) begin xa[xn] = w_mem_addr; xd[xn] = w_mem_wdata; end
      xn++;
    end
    if (core_start) sc++;
    if ((in_ready && !busy) || (w_in_ready && !w_busy)) rbad++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk1); #1; end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    cyc(1);
    load_start = 1'b0;
  endtask

  task automatic clr();
    wn = 0; xn = 0; sc = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    int k;
    in_valid = 1'b0;
    cyc(gap);
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    forever begin
      rdy = in_ready;
      cyc(1);
      if (rdy) break;
      k++;
      if (k > 50) begin
        check("byte_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  function automatic int gp(input int maxgap);
    return (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
  endfunction

  // Sends length, n words from img, and (checksum build) the word sum + bad.
  task automatic load(input logic [15:0] n, input int maxgap, input logic [15:0] bad);
    logic [15:0] s;
    s = 16'h0000;
    send_byte(n[15:8], gp(maxgap));
    send_byte(n[7:0], gp(maxgap));
    for (int i = 0; i < int'(n); i++) begin
      send_byte(img[i][15:8], gp(maxgap));
      send_byte(img[i][7:0], gp(maxgap));
      s = s + img[i];
    end
`ifdef MIPS16_LOADER_CHECKSUM_EN
    s = s + bad;
    send_byte(s[15:8], gp(maxgap));
    send_byte(s[7:0], gp(maxgap));
`else
    if (bad != 16'h0) s = 16'h0;
`endif
    cyc(3);
  endtask

  task automatic check_img9(input string tag);
    check({tag, "_count"}, wn, 9);
    for (int i = 0; i < 9; i++) begin
      check({tag, "_addr"}, wa[i], i);
      check({tag, "_data"}, wd[i], img9[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    cyc(3);
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_core_hold", core_hold, 1);
    check("rst_core_start", core_start, 0);
    check("rst_hlt_seen", hlt_seen, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("start_pc", start_pc, 0);
    check("wrap_start_pc", w_start_pc, 254);
    rst_n = 1'b1;
    cyc(2);
    check("idle_in_ready", in_ready, 0);

    // Nine-word image, one byte per cycle
    for (int i = 0; i < 9; i++) img[i] = img9[i];
    clr();
    pulse_start();
    check("t1_busy", busy, 1);
    check("t1_hold", core_hold, 1);
    check("t1_ready", in_ready, 1);
    load(16'd9, 0, 16'h0);
    check_img9("t1");
    check("t1_hlt", hlt_seen, 1);
    check("t1_start_pulses", sc, 1);
    check("t1_hold_released", core_hold, 0);
    check("t1_busy_done", busy, 0);
    check("t1_error", error, 0);
    check("t1_ready_done", in_ready, 0);

    // Bytes offered in DONE are ignored
    in_valid = 1'b1; in_data = 8'hff;
    cyc(4);
    in_valid = 1'b0;
    check("t1_ignored_bytes", wn, 9);

    // Same image with random valid gaps
    clr();
    pulse_start();
    load(16'd9, 3, 16'h0);
    check_img9("t2");
    check("t2_start_pulses", sc, 1);
    check("t2_ready_outside_load", rbad, 0);

    // Length 0 -> ERR
    clr();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    cyc(2);
    check("t3_len0_error", error, 1);
    check("t3_len0_hold", core_hold, 1);
    check("t3_len0_busy", busy, 0);
    check("t3_len0_ready", in_ready, 0);
    check("t3_len0_hlt_cleared", hlt_seen, 0);
    in_valid = 1'b1; in_data = 8'h12;
    cyc(4);
    in_valid = 1'b0;
    check("t3_len0_writes", wn, 0);

    // Length MAX_WORDS+1 = 257 -> ERR
    pulse_start();
    check("t3_restart_busy", busy, 1);
    check("t3_restart_error_cleared", error, 0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    cyc(2);
    check("t3_len257_error", error, 1);
    check("t3_len257_hold", core_hold, 1);
    check("t3_len257_writes", wn, 0);
    check("t3_no_start", sc, 0);

    // Recovery with a single word
    img[0] = 16'h3ff8;
    pulse_start();
    load(16'd1, 0, 16'h0);
    check("t3_rec_count", wn, 1);
    check("t3_rec_addr", wa[0], 0);
    check("t3_rec_data", wd[0], 16'h3ff8);
    check("t3_rec_hlt", hlt_seen, 0);
    check("t3_rec_error", error, 0);
    check("t3_rec_start", sc, 1);
    check("t3_rec_hold", core_hold, 0);

    // Address wrap on the BASE_ADDR=254 instance
    img[0] = 16'h1111; img[1] = 16'h2222; img[2] = 16'h3333; img[3] = 16'hf444;
    clr();
    pulse_start();
    load(16'd4, 0, 16'h0);
    check("t4_count", xn, 4);
    check("t4_addr0", xa[0], 254);
    check("t4_addr1", xa[1], 255);
    check("t4_addr2", xa[2], 0);
    check("t4_addr3", xa[3], 1);
    check("t4_data2", xd[2], 16'h3333);
    check("t4_data3", xd[3], 16'hf444);
    check("t4_hlt", w_hlt_seen, 1);
    check("t4_hold", w_core_hold, 0);
    check("t4_error", w_error, 0);
    check("t4_base0_addr3", wa[3], 3);

    // Reset after three words
    for (int i = 0; i < 9; i++) img[i] = img9[i];
    clr();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h09, 0);
    for (int i = 0; i < 3; i++) begin
      send_byte(img[i][15:8], 0);
      send_byte(img[i][7:0], 0);
    end
    in_valid = 1'b1; in_data = img[3][15:8];
    @(negedge clk1); #2;
    rst_n = 1'b0;
    #1;
    check("t5_written_before", wn, 3);
    check("t5_rst_mem_we", mem_we, 0);
    check("t5_rst_mem_addr", mem_addr, 0);
    check("t5_rst_mem_wdata", mem_wdata, 0);
    check("t5_rst_in_ready", in_ready, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_hold", core_hold, 1);
    check("t5_rst_start", core_start, 0);
    check("t5_rst_hlt", hlt_seen, 0);
    check("t5_rst_error", error, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    in_valid = 1'b0;
    check("t5_no_writes_after", wn, 3);
    check("t5_idle_busy", busy, 0);
    check("t5_idle_ready", in_ready, 0);
    check("t5_idle_hold", core_hold, 1);

`ifdef MIPS16_LOADER_CHECKSUM_EN
    // Bad checksum -> ERR after all words written
    clr();
    pulse_start();
    load(16'd9, 0, 16'h1);
    check("t6_cs_count", wn, 9);
    check("t6_cs_error", error, 1);
    check("t6_cs_hold", core_hold, 1);
    check("t6_cs_no_start", sc, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
